// File: rtl/axist_multi_incr_gen.sv
// axist_multi_incr_gen
//
// Generates a multi-lane counting pattern on a valid/ready stream. Each beat
// carries NUM_CH lanes of CH_WIDTH bits. Lane k carries base+k for the
// increment, constant and reserved modes, and base-k for the decrement mode.
// After each accepted beat the base moves by +NUM_CH, -NUM_CH or 0.
// A pattern ends after pat_len beats (fixed mode), or after a stop request
// (continuous mode).
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   start        pulse; begins a pattern when idle
//   stop         pulse; ends a continuous-mode pattern
//   cont_mode    1 = run until stop, 0 = run pat_len beats
//   mode_in      00 incr, 01 decr, 10 constant, 11 treated as incr
//   seed_in      starting base value
//   pat_len      beats per fixed-mode pattern (0 means 2^CNT_WIDTH)
//   dout_*       output stream; lane k at dout_data[k*CH_WIDTH +: CH_WIDTH]
//   busy         high while loading or running
//   done         one-cycle pulse when a pattern completes
//   beat_cnt     beats accepted in the current or last pattern

module axist_multi_incr_gen #(
    parameter int NUM_CH    = 4,
    parameter int CH_WIDTH  = 40,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         cont_mode,
    input  logic [1:0]                   mode_in,
    input  logic [CH_WIDTH-1:0]          seed_in,
    input  logic [CNT_WIDTH-1:0]         pat_len,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [NUM_CH*CH_WIDTH-1:0]   dout_data,
    output logic                         dout_last,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_WIDTH-1:0]         beat_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CH_WIDTH-1:0]    base_q, base_d;
    logic [1:0]             mode_q, mode_d;
    logic                   cont_q, cont_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   stop_pend_q, stop_pend_d;

    logic                   run;
    logic                   accept;
    logic                   last;
    logic                   is_dec;
    logic                   is_const;

    // Pattern state registers; reset returns everything to power-up values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            mode_q      <= 2'b00;
            cont_q      <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            mode_q      <= mode_d;
            cont_q      <= cont_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Next-state logic and pattern bookkeeping.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        mode_d      = mode_q;
        cont_d      = cont_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;

        is_dec   = (mode_q == 2'b01);
        is_const = (mode_q == 2'b10);
        run      = (state_q == ST_RUN);
        accept   = run & dout_ready;
        // pat_len of 0 wraps to all-ones here, which yields 2^CNT_WIDTH beats.
        last     = run & (cont_q ? stop_pend_q
                                 : (cnt_q == (len_q - CNT_WIDTH'(1))));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                base_d      = seed_in;
                mode_d      = mode_in;
                cont_d      = cont_mode;
                len_d       = pat_len;
                cnt_d       = '0;
                stop_pend_d = 1'b0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (cont_q && stop) begin
                    stop_pend_d = 1'b1;
                end
                if (accept) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (is_dec) begin
                        base_d = base_q - CH_WIDTH'(NUM_CH);
                    end else if (!is_const) begin
                        base_d = base_q + CH_WIDTH'(NUM_CH);
                    end
                    if (last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Lane data is zeroed outside RUN so that an idle or reset block shows
    // all-zero data rather than the lane offsets.
    always_comb begin
        dout_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (run) begin
                dout_data[k*CH_WIDTH +: CH_WIDTH] =
                    is_dec ? (base_q - CH_WIDTH'(k)) : (base_q + CH_WIDTH'(k));
            end
        end
    end

    assign dout_valid = run;
    assign dout_last  = last;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign beat_cnt   = cnt_q;

endmodule

// File: tb/tb_axist_multi_incr_gen.sv
// Testbench for axist_multi_incr_gen. Expected beats are computed from a
// small reference model and queued when a pattern is started. They are then
// popped and compared as the DUT offers them.

module tb_axist_multi_incr_gen;

    localparam int NUM_CH    = 4;
    localparam int CH_WIDTH  = 40;
    localparam int CNT_WIDTH = 16;
    localparam int DW        = NUM_CH * CH_WIDTH;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  stop;
    logic                  cont_mode;
    logic [1:0]            mode_in;
    logic [CH_WIDTH-1:0]   seed_in;
    logic [CNT_WIDTH-1:0]  pat_len;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [DW-1:0]         dout_data;
    logic                  dout_last;
    logic                  busy;
    logic                  done;
    logic [CNT_WIDTH-1:0]  beat_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    axist_multi_incr_gen #(
        .NUM_CH   (NUM_CH),
        .CH_WIDTH (CH_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cont_mode (cont_mode),
        .mode_in   (mode_in),
        .seed_in   (seed_in),
        .pat_len   (pat_len),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data),
        .dout_last (dout_last),
        .busy      (busy),
        .done      (done),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: lane values for a given base and mode.
    function automatic logic [DW-1:0] model_beat(input logic [CH_WIDTH-1:0] base,
                                                 input logic [1:0] mode);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mode == 2'b01) d[k*CH_WIDTH +: CH_WIDTH] = base - CH_WIDTH'(k);
            else               d[k*CH_WIDTH +: CH_WIDTH] = base + CH_WIDTH'(k);
        end
        return d;
    endfunction

    function automatic logic [CH_WIDTH-1:0] model_next(input logic [CH_WIDTH-1:0] base,
                                                       input logic [1:0] mode);
        case (mode)
            2'b01:   return base - CH_WIDTH'(NUM_CH);
            2'b10:   return base;
            default: return base + CH_WIDTH'(NUM_CH);
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b0 || dout_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            dout_data !== '0 || beat_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state: valid=%b last=%b busy=%b done=%b cnt=%0d data=%h, required all zero",
                     dout_valid, dout_last, busy, done, beat_cnt, dout_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Fixed-length pattern; optionally toggles ready every cycle to stall beats.
    task automatic test_fixed(input string name, input logic [CH_WIDTH-1:0] seed,
                              input logic [1:0] mode, input logic [CNT_WIDTH-1:0] len,
                              input bit toggle);
        logic [CH_WIDTH-1:0] b;
        int cyc;
        int acc;
        b = seed;
        exp_q.delete();
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back('{data: model_beat(b, mode), last: (i == int'(len) - 1)});
            b = model_next(b, mode);
        end
        @(posedge clk); #1;
        seed_in    = seed;
        mode_in    = mode;
        pat_len    = len;
        cont_mode  = 1'b0;
        dout_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || dout_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_load: busy=%b valid=%b, required busy=1 valid=0", name, busy, dout_valid);
        end
        @(posedge clk); #1;
        // Scramble inputs after capture; stop/start must be ignored here.
        seed_in = ~seed;
        mode_in = ~mode;
        pat_len = len + CNT_WIDTH'(3);
        stop    = 1'b1;
        start   = 1'b1;
        cyc = 0;
        acc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            @(negedge clk);
            checks++;
            if (dout_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s_valid: valid=%b after %0d beats, required 1", name, dout_valid, acc);
                break;
            end
            if (dout_data !== exp_q[0].data || dout_last !== exp_q[0].last) begin
                failures++;
                $display("[TB] FAIL %s_beat%0d: data=%h last=%b, required data=%h last=%b",
                         name, acc, dout_data, dout_last, exp_q[0].data, exp_q[0].last);
            end
            if (dout_ready) begin
                void'(exp_q.pop_front());
                acc++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            stop  = 1'b0;
            if (toggle) dout_ready = ~dout_ready;
            cyc++;
        end
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_count: %0d beats still expected, required 0", name, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0 || beat_cnt !== len) begin
            failures++;
            $display("[TB] FAIL %s_done: done=%b busy=%b valid=%b cnt=%0d, required 1 0 0 %0d",
                     name, done, busy, dout_valid, beat_cnt, len);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || beat_cnt !== len) begin
            failures++;
            $display("[TB] FAIL %s_idle: done=%b busy=%b cnt=%0d, required 0 0 %0d",
                     name, done, busy, beat_cnt, len);
        end
        dout_ready = 1'b1;
    endtask

    // Continuous mode: 5 beats accepted, then stop while the 6th is stalled.
    task automatic test_continuous();
        logic [CH_WIDTH-1:0] b;
        int cyc;
        int acc;
        b = 40'h100;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{data: model_beat(b, 2'b00), last: (i == 5)});
            b = model_next(b, 2'b00);
        end
        @(posedge clk); #1;
        seed_in    = 40'h100;
        mode_in    = 2'b00;
        pat_len    = 16'd2;
        cont_mode  = 1'b1;
        dout_ready = 1'b1;
        start      = 1'b1;
        stop       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        @(posedge clk); #1;
        cyc = 0;
        acc = 0;
        while (acc < 5 && cyc < 50) begin
            @(negedge clk);
            checks++;
            if (dout_valid !== 1'b1 || dout_data !== exp_q[0].data || dout_last !== 1'b0) begin
                failures++;
                $display("[TB] FAIL cont_beat%0d: valid=%b data=%h last=%b, required 1 %h 0",
                         acc, dout_valid, dout_data, dout_last, exp_q[0].data);
                break;
            end
            void'(exp_q.pop_front());
            acc++;
            @(posedge clk); #1;
            cyc++;
        end
        dout_ready = 1'b0;
        stop       = 1'b1;
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== exp_q[0].data || dout_last !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cont_stop_cycle: valid=%b data=%h last=%b, required 1 %h 0",
                     dout_valid, dout_data, dout_last, exp_q[0].data);
        end
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== exp_q[0].data || dout_last !== exp_q[0].last) begin
            failures++;
            $display("[TB] FAIL cont_held_last: valid=%b data=%h last=%b, required 1 %h %b",
                     dout_valid, dout_data, dout_last, exp_q[0].data, exp_q[0].last);
        end
        @(posedge clk); #1;
        dout_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== exp_q[0].data || dout_last !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cont_final: valid=%b data=%h last=%b, required 1 %h 1",
                     dout_valid, dout_data, dout_last, exp_q[0].data);
        end
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || beat_cnt !== 16'd6) begin
            failures++;
            $display("[TB] FAIL cont_done: done=%b busy=%b cnt=%0d, required 1 0 6", done, busy, beat_cnt);
        end
        @(posedge clk); #1;
        cont_mode = 1'b0;
    endtask

    // Reset pulse while a pattern is running.
    task automatic test_reset_mid_run();
        @(posedge clk); #1;
        seed_in    = 40'h55;
        mode_in    = 2'b00;
        pat_len    = 16'd10;
        cont_mode  = 1'b1;
        dout_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || dout_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_pre_run: busy=%b valid=%b, required 1 1", busy, dout_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || dout_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            dout_data !== '0 || beat_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL rst_mid_run: valid=%b last=%b busy=%b done=%b cnt=%0d data=%h, required all zero",
                     dout_valid, dout_last, busy, done, beat_cnt, dout_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cont_mode = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_no_done: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        cont_mode  = 1'b0;
        mode_in    = 2'b00;
        seed_in    = '0;
        pat_len    = '0;
        dout_ready = 1'b1;

        test_reset();
        test_fixed("incr",        40'h10, 2'b00, 16'd3, 1'b0);
        test_fixed("incr_toggle", 40'h10, 2'b00, 16'd3, 1'b1);
        test_fixed("decr_wrap",   40'h2,  2'b01, 16'd2, 1'b0);
        test_fixed("const",       40'hAB, 2'b10, 16'd3, 1'b1);
        test_fixed("reserved",    40'hFFFFFFFFFE, 2'b11, 16'd2, 1'b0);
        test_fixed("len1",        40'h20, 2'b00, 16'd1, 1'b1);
        test_continuous();
        test_reset_mid_run();
        test_fixed("after_rst",   40'h77, 2'b00, 16'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
